// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin scheduler sharing one sequential signed multiplier among N_REQ requesters.
// Grants one operand pair at a time, pulses start, waits for ready and routes the product back with valid or err.
module mult_share_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DW      = 8,
    parameter int PW      = 2*DW,
    parameter int TIMEOUT = 64
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [N_REQ*DW-1:0] i_op_a,
    input  logic [N_REQ*DW-1:0] i_op_b,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [N_REQ-1:0]   o_valid,
    output logic [N_REQ-1:0]   o_err,
    output logic [PW-1:0]      o_product,
    output logic               o_busy,
    output logic               o_mult_start,
    output logic [DW-1:0]      o_mult_a,
    output logic [DW-1:0]      o_mult_b,
    input  logic               i_mult_ready,
    input  logic [PW-1:0]      i_mult_product
);
    localparam int PTRW = N_REQ > 1 ? $clog2(N_REQ) : 1;
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, DONE} state_t;

    state_t          state, state_nx;
    logic [PTRW-1:0] ptr, owner, pick, idx, owner_nx;
    logic            found, timeout;
    logic [TW-1:0]   timer;
    logic [DW-1:0]   a, b;
    logic [PW-1:0]   prod;

    // Scan from ptr downwards in priority so the lowest offset from ptr wins.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = PTRW'((int'(ptr) + i) % N_REQ);
            if (i_req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    assign owner_nx = (owner == PTRW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    // A ready seen in WAIT on the last allowed cycle beats the timeout.
    assign timeout  = (state == ARM || state == WAIT) && timer == TW'(TIMEOUT - 1)
                      && !(state == WAIT && i_mult_ready);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            a     <= '0;
            b     <= '0;
            prod  <= '0;
            timer <= '0;
        end else begin
            state <= state_nx;
            timer <= (state == ARM || state == WAIT) ? timer + 1'b1 : '0;
            if (state == IDLE && found) begin
                owner <= pick;
                a     <= i_op_a[pick*DW +: DW];
                b     <= i_op_b[pick*DW +: DW];
            end
            if (state == WAIT && i_mult_ready)
                prod <= i_mult_product;
            if (timeout)
                prod <= '0;
            if (state == DONE || timeout)
                ptr <= owner_nx;
        end
    end

    // ARM gives a stale ready from the previous op at most two cycles to fall.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? ISSUE : IDLE;
            ISSUE:   state_nx = ARM;
            ARM:     state_nx = timeout ? IDLE : (!i_mult_ready || timer == TW'(1)) ? WAIT : ARM;
            WAIT:    state_nx = timeout ? IDLE : i_mult_ready ? DONE : WAIT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_gnt   = '0;
        o_valid = '0;
        o_err   = '0;
        if (state == IDLE && found && !i_rst)
            o_gnt[pick] = 1'b1;
        if (state == DONE)
            o_valid[owner] = 1'b1;
        if (timeout)
            o_err[owner] = 1'b1;
        o_mult_start = state == ISSUE;
        o_busy       = state != IDLE;
        o_product    = timeout ? '0 : prod;
        o_mult_a     = a;
        o_mult_b     = b;
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: vector table plus scoreboard for the shared-multiplier arbiter.
// A behavioural 12-cycle multiplier model supports normal, never-ready and stale-ready modes.
module tb_mult_share_arbiter;
    localparam int DW = 8;
    localparam int PW = 16;
    localparam int TO = 64;

    typedef struct {
        logic [1:0]  req;
        logic [7:0]  a0, b0, a1, b1;
        int          mode;
        logic [1:0]  gnt, valid, err;
        logic [15:0] prod;
    } vec_t;

    typedef struct {
        logic [1:0]  valid, err;
        logic [15:0] prod;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = '0;
    logic [15:0] op_a = '0, op_b = '0;
    logic [1:0]  gnt, valid, err;
    logic [15:0] product, mprod;
    logic        busy, mstart, mready;
    logic [7:0]  ma, mb;

    int   checks = 0, errors = 0, cyc = 0, gnt_cyc = 0, start_cyc = 0;
    int   mode = 0, mcnt = 0;
    exp_t sb[$];
    exp_t e;
    vec_t tbl[13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mult_share_arbiter #(.N_REQ(2), .DW(DW), .PW(PW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_op_a(op_a), .i_op_b(op_b),
        .o_gnt(gnt), .o_valid(valid), .o_err(err), .o_product(product), .o_busy(busy),
        .o_mult_start(mstart), .o_mult_a(ma), .o_mult_b(mb),
        .i_mult_ready(mready), .i_mult_product(mprod)
    );

    // mode 0: normal, mode 1: never ready, mode 2: ready held one cycle past start with junk product
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mready <= 1'b0;
            mcnt   <= 0;
            mprod  <= '0;
        end else if (mstart) begin
            mcnt   <= 12;
            mready <= (mode == 2);
            if (mode == 2) mprod <= 16'hDEAD;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mode == 2 && mcnt == 12) mready <= 1'b0;
            if (mcnt == 1 && mode != 1) begin
                mready <= 1'b1;
                mprod  <= $signed({{8{ma[7]}}, ma}) * $signed({{8{mb[7]}}, mb});
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != 0) gnt_cyc = cyc;
            if (mstart) begin
                check("start_after_gnt", cyc, gnt_cyc + 1);
                start_cyc = cyc;
            end
            if ((gnt | valid | err) != 0)
                check("onehot", $countones(gnt | valid | err), 1);
            if ((valid | err) != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_response", {valid, err}, 0);
                end else begin
                    e = sb.pop_front();
                    check("valid", valid, e.valid);
                    check("err", err, e.err);
                    check("product", product, e.prod);
                end
                if (err != 0) check("timeout_cycles", cyc - start_cyc, TO);
            end
        end
    end

    task automatic do_reset();
        req = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {gnt, valid, err, product, busy, mstart, ma, mb}, 0);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(posedge clk);
        #1;
        req  = v.req;
        op_a = {v.a1, v.a0};
        op_b = {v.b1, v.b0};
        mode = v.mode;
        sb.push_back('{valid: v.valid, err: v.err, prod: v.prod});
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == 0 && n < 100);
        check("gnt", gnt, v.gnt);
        n = 0;
        do begin @(negedge clk); n++; end while ((valid | err) == 0 && n < 200);
        check("response_seen", (valid | err) != 0, 1);
    endtask

    initial begin
        int n, resp;
        tbl[0]  = '{2'b01, 8'hFD, 8'h05, 8'h11, 8'h11, 0, 2'b01, 2'b01, 2'b00, 16'hFFF1};
        tbl[1]  = '{2'b11, 8'h07, 8'h06, 8'hFE, 8'hF7, 0, 2'b01, 2'b01, 2'b00, 16'h002A};
        tbl[2]  = '{2'b11, 8'h07, 8'h06, 8'hFE, 8'hF7, 0, 2'b10, 2'b10, 2'b00, 16'h0012};
        tbl[3]  = '{2'b11, 8'h7F, 8'h7F, 8'h11, 8'h11, 0, 2'b01, 2'b01, 2'b00, 16'h3F01};
        tbl[4]  = '{2'b11, 8'h11, 8'h11, 8'h80, 8'h7F, 0, 2'b10, 2'b10, 2'b00, 16'hC080};
        tbl[5]  = '{2'b11, 8'hFF, 8'hFF, 8'h11, 8'h11, 0, 2'b01, 2'b01, 2'b00, 16'h0001};
        tbl[6]  = '{2'b11, 8'h11, 8'h11, 8'h00, 8'hFB, 0, 2'b10, 2'b10, 2'b00, 16'h0000};
        tbl[7]  = '{2'b11, 8'h80, 8'h01, 8'h11, 8'h11, 0, 2'b01, 2'b01, 2'b00, 16'hFF80};
        tbl[8]  = '{2'b11, 8'h11, 8'h11, 8'h64, 8'hFD, 0, 2'b10, 2'b10, 2'b00, 16'hFED4};
        tbl[9]  = '{2'b10, 8'h00, 8'h00, 8'h03, 8'h03, 1, 2'b10, 2'b00, 2'b10, 16'h0000};
        tbl[10] = '{2'b10, 8'h00, 8'h00, 8'h03, 8'h03, 0, 2'b10, 2'b10, 2'b00, 16'h0009};
        tbl[11] = '{2'b01, 8'hF9, 8'h09, 8'h00, 8'h00, 2, 2'b01, 2'b01, 2'b00, 16'hFFC1};
        tbl[12] = '{2'b01, 8'h80, 8'h80, 8'h00, 8'h00, 0, 2'b01, 2'b01, 2'b00, 16'h4000};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i == 1) do_reset();
            run_vec(tbl[i]);
        end

        // abort an op in WAIT with an asynchronous reset
        @(posedge clk);
        #1;
        req  = 2'b01;
        op_a = 16'h0080;
        op_b = 16'h0080;
        mode = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == 0 && n < 100);
        check("midop_gnt", gnt, 2'b01);
        repeat (6) @(negedge clk);
        check("midop_busy", busy, 1);
        req = '0;
        #2 rst = 1'b1;
        #1 check("midop_reset_outputs", {gnt, valid, err, product, busy, mstart, ma, mb}, 0);
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        resp = 0;
        repeat (20) begin
            @(negedge clk);
            if ((valid | err) != 0) resp++;
        end
        check("no_resp_after_reset", resp, 0);
        run_vec(tbl[12]);

        @(posedge clk);
        #1 req = '0;
        repeat (30) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
